sgmii_pcs_config_controller: RTL



---
 rtl/sgmii_pcs_pkg.sv | 43 ++++
 rtl/sgmii_pcs_config_controller_reg_access.sv | 85 ++++++++
 rtl/sgmii_pcs_config_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sgmii_pcs_pkg.sv
// Shared register map, configuration words and state encoding for the
// SGMII PCS configuration controller.
package sgmii_pcs_pkg;

    localparam logic [4:0] REG_CTRL    = 5'h00;
    localparam logic [4:0] REG_STATUS  = 5'h01;
    localparam logic [4:0] REG_PARTNER = 5'h05;
    localparam logic [4:0] REG_LT0     = 5'h12;
    localparam logic [4:0] REG_LT1     = 5'h13;
    localparam logic [4:0] REG_IF_MODE = 5'h14;

    localparam int CTRL_RESET_BIT     = 15;
    localparam int STATUS_LINK_BIT    = 2;
    localparam int STATUS_AN_DONE_BIT = 5;
    localparam int PARTNER_LINK_BIT   = 15;
    localparam int PARTNER_DUPLEX_BIT = 12;
    localparam int PARTNER_SPEED_LSB  = 10;

    localparam logic [15:0] CTRL_INIT_WORD       = 16'h9140;
    localparam logic [15:0] CTRL_AN_RESTART_WORD = 16'h1340;
    localparam logic [15:0] IF_MODE_SGMII_WORD   = 16'h0003;

    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10
    } speed_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_IF_MODE,
        ST_WR_LT0,
        ST_WR_LT1,
        ST_WR_CTRL,
        ST_POLL_RST,
        ST_WAIT,
        ST_RD_STATUS,
        ST_RD_PARTNER,
        ST_WR_AN_RESTART,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/sgmii_pcs_config_controller_reg_access.sv
// Single register-access handshake engine: holds one strobe until the PCS
// reports not-busy (from the 2nd strobe cycle on), a timeout, or an abort.
module pcs_reg_access #(
    parameter int p_ACCESS_TIMEOUT_TICKS = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        wr_i,
    input  logic        abort_i,
    input  logic [4:0]  addr_i,
    input  logic [15:0] wdata_i,
    input  logic        busy_i,
    input  logic [15:0] rdata_i,
    output logic [4:0]  reg_addr_o,
    output logic        reg_rd_o,
    output logic        reg_wr_o,
    output logic [15:0] reg_wdata_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        timeout_o
);
    localparam int CNT_W = $clog2(p_ACCESS_TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_ACCESS_TIMEOUT_TICKS - 1);

    logic             strobe_q, strobe_d;
    logic             wr_q, wr_d;
    logic [4:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        strobe_d  = strobe_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        if (abort_i) begin
            strobe_d = 1'b0;
        end else if (strobe_q) begin
            // cnt_q counts strobe cycles already elapsed; non-zero means 2nd cycle or later
            if ((cnt_q != '0) && !busy_i) begin
                done_o   = 1'b1;
                strobe_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                timeout_o = 1'b1;
                strobe_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (start_i) begin
            strobe_d = 1'b1;
            wr_d     = wr_i;
            addr_d   = addr_i;
            wdata_d  = wdata_i;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            strobe_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 5'h00;
            wdata_q  <= 16'h0000;
            cnt_q    <= '0;
        end else begin
            strobe_q <= strobe_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Abort gates the strobe combinationally so it falls in the abort cycle itself.
    assign reg_rd_o    = strobe_q & ~wr_q & ~abort_i;
    assign reg_wr_o    = strobe_q & wr_q & ~abort_i;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign rdata_o     = rdata_i;

endmodule

// File: rtl/sgmii_pcs_config_controller.sv
// Sequences SGMII PCS setup writes, then polls link/partner status and
// exports link, speed and duplex; supervises auto-negotiation progress.
module sgmii_pcs_config_controller
    import sgmii_pcs_pkg::*;
#(
    parameter int          p_POLL_INTERVAL_TICKS  = 125000,
    parameter int          p_ACCESS_TIMEOUT_TICKS = 64,
    parameter int          p_AN_TIMEOUT_POLLS     = 50,
    parameter logic [19:0] p_LINK_TIMER           = 20'h30D40
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_restart,
    output logic [4:0]  o_reg_addr,
    output logic        o_reg_rd,
    output logic        o_reg_wr,
    output logic [15:0] o_reg_data_out,
    input  logic [15:0] i_reg_data_in,
    input  logic        i_reg_busy,
    output logic        o_config_done,
    output logic        o_link_up,
    output logic [1:0]  o_speed,
    output logic        o_full_duplex,
    output logic        o_error
);
    localparam int WAIT_W = $clog2(p_POLL_INTERVAL_TICKS + 1);
    localparam int AN_W   = $clog2(p_AN_TIMEOUT_POLLS + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(p_POLL_INTERVAL_TICKS - 1);
    localparam logic [AN_W-1:0]   AN_LAST   = AN_W'(p_AN_TIMEOUT_POLLS - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [AN_W-1:0]   an_cnt_q, an_cnt_d;
    logic              st_link_q, st_link_d, st_an_q, st_an_d;
    logic              cfg_done_q, cfg_done_d, link_up_q, link_up_d;
    logic              duplex_q, duplex_d, error_q, error_d;
    logic [1:0]        speed_q, speed_d;
    logic              acc_start, acc_wr, acc_done, acc_timeout, partner_link;
    logic [4:0]        acc_addr;
    logic [15:0]       acc_wdata, acc_rdata;
    logic              unused_rdata_bits;

    assign unused_rdata_bits = ^{acc_rdata[14:13], acc_rdata[9:6], acc_rdata[4:3], acc_rdata[1:0]};

    pcs_reg_access #(
        .p_ACCESS_TIMEOUT_TICKS(p_ACCESS_TIMEOUT_TICKS)
    ) u_access (
        .clk_i      (i_clock),
        .rst_n_i    (i_reset_n),
        .start_i    (acc_start),
        .wr_i       (acc_wr),
        .abort_i    (i_restart),
        .addr_i     (acc_addr),
        .wdata_i    (acc_wdata),
        .busy_i     (i_reg_busy),
        .rdata_i    (i_reg_data_in),
        .reg_addr_o (o_reg_addr),
        .reg_rd_o   (o_reg_rd),
        .reg_wr_o   (o_reg_wr),
        .reg_wdata_o(o_reg_data_out),
        .done_o     (acc_done),
        .rdata_o    (acc_rdata),
        .timeout_o  (acc_timeout)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = WAIT_LOAD;
        an_cnt_d     = an_cnt_q;
        st_link_d    = st_link_q;
        st_an_d      = st_an_q;
        cfg_done_d   = cfg_done_q;
        link_up_d    = link_up_q;
        speed_d      = speed_q;
        duplex_d     = duplex_q;
        error_d      = error_q;
        acc_start    = 1'b0;
        acc_wr       = 1'b0;
        acc_addr     = REG_CTRL;
        acc_wdata    = 16'h0000;
        partner_link = st_link_q & st_an_q & acc_rdata[PARTNER_LINK_BIT];
        case (state_q)
            ST_IDLE: state_d = ST_WR_IF_MODE;
            ST_WR_IF_MODE: begin
                {acc_start, acc_wr, acc_addr, acc_wdata} = {2'b11, REG_IF_MODE, IF_MODE_SGMII_WORD};
                if (acc_done) state_d = ST_WR_LT0;
            end
            ST_WR_LT0: begin
                {acc_start, acc_wr, acc_addr, acc_wdata} = {2'b11, REG_LT0, p_LINK_TIMER[15:0]};
                if (acc_done) state_d = ST_WR_LT1;
            end
            ST_WR_LT1: begin
                {acc_start, acc_wr, acc_addr, acc_wdata} = {2'b11, REG_LT1, 12'h000, p_LINK_TIMER[19:16]};
                if (acc_done) state_d = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                {acc_start, acc_wr, acc_addr, acc_wdata} = {2'b11, REG_CTRL, CTRL_INIT_WORD};
                if (acc_done) state_d = ST_POLL_RST;
            end
            ST_POLL_RST: begin
                {acc_start, acc_addr} = {1'b1, REG_CTRL};
                if (acc_done && !acc_rdata[CTRL_RESET_BIT]) begin
                    cfg_done_d = 1'b1;
                    state_d    = ST_RD_STATUS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) state_d = ST_RD_STATUS;
                else                  wait_cnt_d = wait_cnt_q - 1'b1;
            end
            ST_RD_STATUS: begin
                {acc_start, acc_addr} = {1'b1, REG_STATUS};
                if (acc_done) begin
                    st_link_d = acc_rdata[STATUS_LINK_BIT];
                    st_an_d   = acc_rdata[STATUS_AN_DONE_BIT];
                    state_d   = ST_RD_PARTNER;
                end
            end
            ST_RD_PARTNER: begin
                {acc_start, acc_addr} = {1'b1, REG_PARTNER};
                if (acc_done) begin
                    link_up_d = partner_link;
                    if (partner_link) begin
                        speed_d  = acc_rdata[PARTNER_SPEED_LSB +: 2];
                        duplex_d = acc_rdata[PARTNER_DUPLEX_BIT];
                    end
                    state_d = ST_WAIT;
                    if (st_an_q) begin
                        an_cnt_d = '0;
                    end else if (an_cnt_q == AN_LAST) begin
                        an_cnt_d = '0;
                        state_d  = ST_WR_AN_RESTART;
                    end else begin
                        an_cnt_d = an_cnt_q + 1'b1;
                    end
                end
            end
            ST_WR_AN_RESTART: begin
                {acc_start, acc_wr, acc_addr, acc_wdata} = {2'b11, REG_CTRL, CTRL_AN_RESTART_WORD};
                if (acc_done) state_d = ST_WAIT;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
        if (acc_timeout) begin
            error_d = 1'b1;
            state_d = ST_FAULT;
        end
        // Restart overrides everything, including a completion in the same cycle.
        if (i_restart) begin
            state_d    = ST_WR_IF_MODE;
            cfg_done_d = 1'b0;
            link_up_d  = 1'b0;
            error_d    = 1'b0;
            an_cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            an_cnt_q   <= '0;
            st_link_q  <= 1'b0;
            st_an_q    <= 1'b0;
            cfg_done_q <= 1'b0;
            link_up_q  <= 1'b0;
            speed_q    <= SPEED_10M;
            duplex_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            an_cnt_q   <= an_cnt_d;
            st_link_q  <= st_link_d;
            st_an_q    <= st_an_d;
            cfg_done_q <= cfg_done_d;
            link_up_q  <= link_up_d;
            speed_q    <= speed_d;
            duplex_q   <= duplex_d;
            error_q    <= error_d;
        end
    end

    assign o_config_done = cfg_done_q;
    assign o_link_up     = link_up_q;
    assign o_speed       = speed_q;
    assign o_full_duplex = duplex_q;
    assign o_error       = error_q;

endmodule
